// File: rtl/ddr_ca_lane_tx_ctrl.sv
// ---------------------------------------------------------------------------
// ddr_ca_lane_tx_ctrl
//   Fabric-side controller for a group of output-only DDR command/address IOD
//   lanes. It pipelines the per-lane serialiser data and output-enable words
//   toward the IODs. It also sequences the lanes' dynamic output delay lines
//   (MOVE/DIRECTION/LOAD) from a request/done interface, tracking the tap
//   index of every lane.
//
// Ports
//   clk, rst_n                  fabric clock, async active-low reset
//   cmd_data_i / cmd_oe_i       LANES*RATIO serialiser words, lane i at
//                               [i*RATIO +: RATIO], bit 0 sent first
//   tx_data_o / oe_data_o       pipelined words to the IODs
//   dly_req_valid_i/ready_o     delay request handshake
//   dly_req_lane_i/op_i/steps_i target lane, op (00 inc, 01 dec, 10 load,
//                               11 reserved), number of tap moves
//   dly_done_o / dly_err_o      one-cycle completion pulse and error flag
//   dly_tap_o                   tracked tap per lane, TAP_W bits each
//   delay_line_move_o/direction_o/load_o   per-lane IOD delay controls
//                               (direction 1 = increment)
//   delay_line_out_of_range_i   per-lane limit flag from the IODs
// ---------------------------------------------------------------------------
module ddr_ca_lane_tx_ctrl #(
  parameter int LANES    = 8,
  parameter int RATIO    = 4,
  parameter int PIPE     = 1,
  parameter int MAX_TAP  = 127,
  parameter int INIT_TAP = 1,
  parameter int MOVE_GAP = 4,
  parameter bit IDLE_VAL = 1'b1,
  localparam int TAP_W   = $clog2(MAX_TAP + 1),
  localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int DW      = LANES * RATIO
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DW-1:0]          cmd_data_i,
  input  logic [DW-1:0]          cmd_oe_i,
  output logic [DW-1:0]          tx_data_o,
  output logic [DW-1:0]          oe_data_o,
  input  logic                   dly_req_valid_i,
  output logic                   dly_req_ready_o,
  input  logic [LANE_W-1:0]      dly_req_lane_i,
  input  logic [1:0]             dly_req_op_i,
  input  logic [7:0]             dly_req_steps_i,
  output logic                   dly_done_o,
  output logic                   dly_err_o,
  output logic [LANES*TAP_W-1:0] dly_tap_o,
  output logic [LANES-1:0]       delay_line_move_o,
  output logic [LANES-1:0]       delay_line_direction_o,
  output logic [LANES-1:0]       delay_line_load_o,
  input  logic [LANES-1:0]       delay_line_out_of_range_i
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_MOVE, S_GAP, S_LOAD, S_DONE} state_e;
  typedef enum logic [1:0] {OP_INC = 2'b00, OP_DEC = 2'b01, OP_LOAD = 2'b10, OP_RSVD = 2'b11} op_e;

  localparam logic [TAP_W-1:0]  MAX_TAP_C  = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0]  INIT_TAP_C = TAP_W'(INIT_TAP);
  localparam logic [TAP_W-1:0]  TAP_ONE    = TAP_W'(1);
  localparam logic [3:0]        GAP_INIT   = 4'(MOVE_GAP - 1);
  localparam logic [LANE_W:0]   LANES_C    = (LANE_W + 1)'(LANES);

  // ------------------------------------------------------------ data path
  logic [DW-1:0] tx_pipe_q [PIPE];
  logic [DW-1:0] oe_pipe_q [PIPE];

  // NOTE: the pipeline stages are plain registers, so they are reset to the
  // idle line state; command pins then idle high with drivers disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < PIPE; s++) begin
        tx_pipe_q[s] <= {DW{IDLE_VAL}};
        oe_pipe_q[s] <= '0;
      end
    end else begin
      tx_pipe_q[0] <= cmd_data_i;
      oe_pipe_q[0] <= cmd_oe_i;
      for (int s = 1; s < PIPE; s++) begin
        tx_pipe_q[s] <= tx_pipe_q[s-1];
        oe_pipe_q[s] <= oe_pipe_q[s-1];
      end
    end
  end

  assign tx_data_o = tx_pipe_q[PIPE-1];
  assign oe_data_o = oe_pipe_q[PIPE-1];

  // --------------------------------------------------------- delay control
  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [7:0]        steps_q, steps_d;
  logic [3:0]        gap_q, gap_d;
  logic              err_d;
  logic              ready_q, done_q, err_q;
  logic [LANES-1:0]  move_q, load_q, dir_q, lane_onehot_d;
  logic [TAP_W-1:0]  tap_q [LANES];
  logic [TAP_W-1:0]  cur_tap;
  logic              lane_ok, is_inc, at_limit;

  // NOTE: every signal written here gets a default first, so no latch is
  // inferred on paths that leave it untouched.
  always_comb begin
    lane_ok  = ({1'b0, lane_q} < LANES_C);
    cur_tap  = lane_ok ? tap_q[lane_q] : '0;
    is_inc   = (op_q == OP_INC);
    // Limit for the move that would come next in the current direction.
    at_limit = is_inc ? (cur_tap == MAX_TAP_C) : (cur_tap == '0);

    state_d = state_q;
    op_d    = op_q;
    lane_d  = lane_q;
    steps_d = steps_q;
    gap_d   = gap_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dly_req_valid_i && ready_q) begin
          lane_d  = dly_req_lane_i;
          op_d    = op_e'(dly_req_op_i);
          steps_d = dly_req_steps_i;
          state_d = (op_e'(dly_req_op_i) == OP_LOAD) ? S_LOAD : S_SETUP;
        end
      end
      S_SETUP: begin
        if (op_q == OP_RSVD || !lane_ok || at_limit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else if (steps_q == 8'd0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        steps_d = steps_q - 8'd1;
        gap_d   = GAP_INIT;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else if (delay_line_out_of_range_i[lane_q]) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else if (steps_q == 8'd0) begin
          state_d = S_DONE;
        end else if (at_limit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = S_MOVE;
        end
      end
      S_LOAD:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < LANES; i++) begin
      lane_onehot_d[i] = ({1'b0, lane_d} == (LANE_W + 1)'(i));
    end
  end

  // Outputs are registered from the next state, so each one is a clean
  // decode of the current state with no combinational path to the IODs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_INC;
      lane_q  <= '0;
      steps_q <= '0;
      gap_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      move_q  <= '0;
      load_q  <= '0;
      dir_q   <= '0;
      for (int i = 0; i < LANES; i++) tap_q[i] <= INIT_TAP_C;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      steps_q <= steps_d;
      gap_q   <= gap_d;
      ready_q <= (state_d == S_IDLE);
      done_q  <= (state_d == S_DONE);
      err_q   <= err_d;
      move_q  <= (state_d == S_MOVE) ? lane_onehot_d : '0;
      load_q  <= (state_d == S_LOAD) ? lane_onehot_d : '0;
      dir_q   <= ((state_d inside {S_SETUP, S_MOVE, S_GAP}) && op_d == OP_INC)
                 ? lane_onehot_d : '0;
      // Tap tracks the pulse that is ending on this edge; limits were checked
      // before the move was issued, so no wrap is possible.
      if (state_q == S_MOVE) begin
        tap_q[lane_q] <= is_inc ? cur_tap + TAP_ONE : cur_tap - TAP_ONE;
      end else if (state_q == S_LOAD && lane_ok) begin
        tap_q[lane_q] <= INIT_TAP_C;
      end
    end
  end

  assign dly_req_ready_o        = ready_q;
  assign dly_done_o             = done_q;
  assign dly_err_o              = err_q;
  assign delay_line_move_o      = move_q;
  assign delay_line_load_o      = load_q;
  assign delay_line_direction_o = dir_q;

  for (genvar g = 0; g < LANES; g++) begin : g_tap_out
    assign dly_tap_o[g*TAP_W +: TAP_W] = tap_q[g];
  end

endmodule

// File: tb/tb_ddr_ca_lane_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ddr_ca_lane_tx_ctrl
//   Directed bench for ddr_ca_lane_tx_ctrl (LANES=8, RATIO=4, PIPE=2,
//   MOVE_GAP=4, MAX_TAP=127, INIT_TAP=1). Outputs are sampled on the falling
//   edge, i.e. the value seen at a negedge is the value present at the next
//   rising edge. Cycle offsets k are counted from the accepting edge T.
// ---------------------------------------------------------------------------
module tb_ddr_ca_lane_tx_ctrl;

  localparam int TAP_W = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cmd_data, cmd_oe, tx_data, oe_data;
  logic        req_valid, req_ready;
  logic [2:0]  req_lane;
  logic [1:0]  req_op;
  logic [7:0]  req_steps;
  logic        done, err;
  logic [55:0] taps;
  logic [7:0]  mv, dir, ld, oor;

  int checks = 0;
  int passed = 0;

  // Results of the last do_req call.
  int   moves[$];
  int   done_k, load_k;
  logic err_v, stray, dir_bad, ready_after;

  always #5 clk = ~clk;

  ddr_ca_lane_tx_ctrl #(.LANES(8), .RATIO(4), .PIPE(2), .MAX_TAP(127),
                        .INIT_TAP(1), .MOVE_GAP(4), .IDLE_VAL(1'b1)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .cmd_data_i                (cmd_data),
    .cmd_oe_i                  (cmd_oe),
    .tx_data_o                 (tx_data),
    .oe_data_o                 (oe_data),
    .dly_req_valid_i           (req_valid),
    .dly_req_ready_o           (req_ready),
    .dly_req_lane_i            (req_lane),
    .dly_req_op_i              (req_op),
    .dly_req_steps_i           (req_steps),
    .dly_done_o                (done),
    .dly_err_o                 (err),
    .dly_tap_o                 (taps),
    .delay_line_move_o         (mv),
    .delay_line_direction_o    (dir),
    .delay_line_load_o         (ld),
    .delay_line_out_of_range_i (oor)
  );

  function automatic logic [TAP_W-1:0] tap_of(input int l);
    return taps[l*TAP_W +: TAP_W];
  endfunction

  function automatic int move_at(input int j);
    return (moves.size() > j) ? moves[j] : -1;
  endfunction

  // Issue one request and watch the lane controls until DONE (bounded).
  task automatic do_req(input int lane, input logic [1:0] op,
                        input logic [7:0] steps, input int oor_after);
    logic [7:0] mask;
    logic       exp_dir, prev_dir;
    mask     = 8'(1 << lane);
    exp_dir  = (op == 2'b00);
    prev_dir = 1'b0;
    moves.delete();
    done_k = -1; load_k = -1;
    err_v = 1'b0; stray = 1'b0; dir_bad = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_lane = 3'(lane); req_op = op; req_steps = steps;
    @(posedge clk);
    for (int k = 1; k <= 1000 && done_k < 0; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mv[lane]) begin
        moves.push_back(k);
        if (dir[lane] !== exp_dir || prev_dir !== exp_dir) dir_bad = 1'b1;
      end
      prev_dir = dir[lane];
      if (ld[lane]) load_k = k;
      if (((mv | ld | dir) & ~mask) != 8'h00) stray = 1'b1;
      if (done) begin
        done_k = k;
        err_v  = err;
      end
      if (oor_after > 0 && moves.size() >= oor_after) oor[lane] = 1'b1;
    end
    oor = '0;
    @(negedge clk);
    ready_after = req_ready;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_data = '0; cmd_oe = 32'hFFFF_FFFF; oor = '0;
    req_valid = 1'b0; req_lane = '0; req_op = '0; req_steps = '0;
    repeat (3) @(negedge clk);
    checks++; if (tx_data !== 32'hFFFF_FFFF) $display("FAIL rst_tx_data: got %h expected ffffffff", tx_data); else passed++;
    checks++; if (oe_data !== 32'h0) $display("FAIL rst_oe_data: got %h expected 00000000", oe_data); else passed++;
    checks++; if (req_ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", req_ready); else passed++;
    checks++; if ({mv, dir, ld} !== 24'h0) $display("FAIL rst_controls: got %h expected 000000", {mv, dir, ld}); else passed++;
    checks++; if ({done, err} !== 2'b00) $display("FAIL rst_done_err: got %b expected 00", {done, err}); else passed++;
    for (int l = 0; l < 8; l++) begin
      checks++; if (tap_of(l) !== 7'd1) $display("FAIL rst_tap%0d: got %0d expected 1", l, tap_of(l)); else passed++;
    end
    cmd_oe = '0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready_release: got %b expected 1", req_ready); else passed++;
  endtask

  task automatic test_data_path;
    logic [31:0] dvec [4];
    logic [31:0] ovec [4];
    dvec = '{32'h0000_A000, 32'h5A5A_3C3C, 32'hFFFF_0001, 32'h1234_5678};
    ovec = '{32'h0000_F000, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'h8000_0001};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++; if (tx_data !== 32'h0) $display("FAIL data_early: got %h expected 00000000", tx_data); else passed++;
      end
      if (i >= 2) begin
        checks++; if (tx_data !== dvec[i-2]) $display("FAIL data_vec%0d: got %h expected %h", i-2, tx_data, dvec[i-2]); else passed++;
        checks++; if (oe_data !== ovec[i-2]) $display("FAIL oe_vec%0d: got %h expected %h", i-2, oe_data, ovec[i-2]); else passed++;
      end
      if (i == 2) begin
        checks++; if (tx_data[15:12] !== 4'b1010) $display("FAIL data_lane3: got %b expected 1010", tx_data[15:12]); else passed++;
      end
      if (i < 4) begin
        cmd_data = dvec[i];
        cmd_oe   = ovec[i];
      end
    end
  endtask

  task automatic test_increment;
    do_req(5, 2'b00, 8'd3, 0);
    checks++; if (moves.size() !== 3) $display("FAIL inc_move_count: got %0d expected 3", moves.size()); else passed++;
    for (int j = 0; j < 3; j++) begin
      checks++; if (move_at(j) !== 2 + 5*j) $display("FAIL inc_move%0d_cycle: got %0d expected %0d", j, move_at(j), 2 + 5*j); else passed++;
    end
    checks++; if (done_k !== 17) $display("FAIL inc_done_cycle: got %0d expected 17", done_k); else passed++;
    checks++; if (err_v !== 1'b0) $display("FAIL inc_err: got %b expected 0", err_v); else passed++;
    checks++; if (tap_of(5) !== 7'd4) $display("FAIL inc_tap5: got %0d expected 4", tap_of(5)); else passed++;
    checks++; if (tap_of(4) !== 7'd1) $display("FAIL inc_tap4: got %0d expected 1", tap_of(4)); else passed++;
    checks++; if (stray !== 1'b0) $display("FAIL inc_other_lanes: got %b expected 0", stray); else passed++;
    checks++; if (dir_bad !== 1'b0) $display("FAIL inc_direction: got %b expected 0", dir_bad); else passed++;
    checks++; if (ready_after !== 1'b1) $display("FAIL inc_ready_after: got %b expected 1", ready_after); else passed++;
  endtask

  task automatic test_decrement;
    do_req(0, 2'b01, 8'd5, 0);
    checks++; if (moves.size() !== 1) $display("FAIL dec_move_count: got %0d expected 1", moves.size()); else passed++;
    checks++; if (move_at(0) !== 2) $display("FAIL dec_move_cycle: got %0d expected 2", move_at(0)); else passed++;
    checks++; if (done_k !== 7) $display("FAIL dec_done_cycle: got %0d expected 7", done_k); else passed++;
    checks++; if (err_v !== 1'b1) $display("FAIL dec_err: got %b expected 1", err_v); else passed++;
    checks++; if (tap_of(0) !== 7'd0) $display("FAIL dec_tap0: got %0d expected 0", tap_of(0)); else passed++;
    checks++; if (tap_of(5) !== 7'd4) $display("FAIL dec_tap5_kept: got %0d expected 4", tap_of(5)); else passed++;
    checks++; if (stray !== 1'b0) $display("FAIL dec_other_lanes: got %b expected 0", stray); else passed++;
  endtask

  task automatic test_out_of_range;
    do_req(2, 2'b00, 8'd5, 2);
    checks++; if (moves.size() !== 2) $display("FAIL oor_move_count: got %0d expected 2", moves.size()); else passed++;
    checks++; if (move_at(1) !== 7) $display("FAIL oor_move2_cycle: got %0d expected 7", move_at(1)); else passed++;
    checks++; if (done_k !== 12) $display("FAIL oor_done_cycle: got %0d expected 12", done_k); else passed++;
    checks++; if (err_v !== 1'b1) $display("FAIL oor_err: got %b expected 1", err_v); else passed++;
    checks++; if (tap_of(2) !== 7'd3) $display("FAIL oor_tap2: got %0d expected 3", tap_of(2)); else passed++;
  endtask

  task automatic test_load_and_reserved;
    do_req(7, 2'b00, 8'd2, 0);
    checks++; if (tap_of(7) !== 7'd3) $display("FAIL load_pre_tap7: got %0d expected 3", tap_of(7)); else passed++;
    do_req(7, 2'b10, 8'd9, 0);
    checks++; if (load_k !== 1) $display("FAIL load_pulse_cycle: got %0d expected 1", load_k); else passed++;
    checks++; if (done_k !== 2) $display("FAIL load_done_cycle: got %0d expected 2", done_k); else passed++;
    checks++; if (err_v !== 1'b0) $display("FAIL load_err: got %b expected 0", err_v); else passed++;
    checks++; if (moves.size() !== 0) $display("FAIL load_moves: got %0d expected 0", moves.size()); else passed++;
    checks++; if (tap_of(7) !== 7'd1) $display("FAIL load_tap7: got %0d expected 1", tap_of(7)); else passed++;
    checks++; if (ready_after !== 1'b1) $display("FAIL load_ready_after: got %b expected 1", ready_after); else passed++;
    do_req(1, 2'b11, 8'd3, 0);
    checks++; if (done_k !== 2) $display("FAIL rsvd_done_cycle: got %0d expected 2", done_k); else passed++;
    checks++; if (err_v !== 1'b1) $display("FAIL rsvd_err: got %b expected 1", err_v); else passed++;
    checks++; if (moves.size() !== 0 || load_k !== -1) $display("FAIL rsvd_pulses: got moves %0d load %0d expected 0 and -1", moves.size(), load_k); else passed++;
    checks++; if (tap_of(1) !== 7'd1) $display("FAIL rsvd_tap1: got %0d expected 1", tap_of(1)); else passed++;
    do_req(4, 2'b00, 8'd0, 0);
    checks++; if (done_k !== 2) $display("FAIL zero_done_cycle: got %0d expected 2", done_k); else passed++;
    checks++; if (err_v !== 1'b0) $display("FAIL zero_err: got %b expected 0", err_v); else passed++;
    checks++; if (moves.size() !== 0) $display("FAIL zero_moves: got %0d expected 0", moves.size()); else passed++;
  endtask

  task automatic test_tap_limits;
    do_req(6, 2'b00, 8'd200, 0);
    checks++; if (moves.size() !== 126) $display("FAIL max_move_count: got %0d expected 126", moves.size()); else passed++;
    checks++; if (done_k !== 632) $display("FAIL max_done_cycle: got %0d expected 632", done_k); else passed++;
    checks++; if (err_v !== 1'b1) $display("FAIL max_err: got %b expected 1", err_v); else passed++;
    checks++; if (tap_of(6) !== 7'd127) $display("FAIL max_tap6: got %0d expected 127", tap_of(6)); else passed++;
    do_req(6, 2'b00, 8'd1, 0);
    checks++; if (done_k !== 2 || err_v !== 1'b1) $display("FAIL max_setup_err: got done %0d err %b expected 2 and 1", done_k, err_v); else passed++;
    checks++; if (moves.size() !== 0 || tap_of(6) !== 7'd127) $display("FAIL max_no_wrap: got moves %0d tap %0d expected 0 and 127", moves.size(), tap_of(6)); else passed++;
    do_req(0, 2'b01, 8'd1, 0);
    checks++; if (done_k !== 2 || err_v !== 1'b1) $display("FAIL min_setup_err: got done %0d err %b expected 2 and 1", done_k, err_v); else passed++;
    checks++; if (moves.size() !== 0 || tap_of(0) !== 7'd0) $display("FAIL min_no_wrap: got moves %0d tap %0d expected 0 and 0", moves.size(), tap_of(0)); else passed++;
  endtask

  task automatic test_reset_mid;
    logic seen, spurious;
    seen = 1'b0; spurious = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_lane = 3'd3; req_op = 2'b00; req_steps = 8'd4;
    @(posedge clk);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mv[3]) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) $display("FAIL rmid_first_move: got %b expected 1", seen); else passed++;
    repeat (2) @(negedge clk);
    checks++; if (tap_of(3) !== 7'd2 || dir[3] !== 1'b1) $display("FAIL rmid_pre_state: got tap %0d dir %b expected 2 and 1", tap_of(3), dir[3]); else passed++;
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({mv, dir, ld} !== 24'h0) $display("FAIL rmid_controls: got %h expected 000000", {mv, dir, ld}); else passed++;
    checks++; if ({done, err, req_ready} !== 3'b000) $display("FAIL rmid_done_err_ready: got %b expected 000", {done, err, req_ready}); else passed++;
    checks++; if (tap_of(3) !== 7'd1 || tap_of(5) !== 7'd1 || tap_of(6) !== 7'd1) $display("FAIL rmid_taps: got %0d %0d %0d expected 1 1 1", tap_of(3), tap_of(5), tap_of(6)); else passed++;
    repeat (3) begin
      @(negedge clk);
      if (done || mv != 8'h00) spurious = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) $display("FAIL rmid_ready_release: got %b expected 1", req_ready); else passed++;
    repeat (20) begin
      @(negedge clk);
      if (done || mv != 8'h00) spurious = 1'b1;
    end
    checks++; if (spurious !== 1'b0) $display("FAIL rmid_no_done: got %b expected 0", spurious); else passed++;
  endtask

  initial begin
    test_reset();
    test_data_path();
    test_increment();
    test_decrement();
    test_out_of_range();
    test_load_and_reserved();
    test_tap_limits();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ddr_ca_lane_tx_ctrl.md
# ddr_ca_lane_tx_ctrl

Parametrised fabric-side controller for a group of output-only DDR command/address IOD lanes. It pipelines per-lane RATIO:1 serialiser data and output-enable words toward the IODs. It also owns the lanes' dynamic output delay lines through a request/done interface that generates MOVE/DIRECTION/LOAD sequences, tracks the tap count of every lane and aborts on out-of-range. It sits between the DDR command scheduler/training logic and the per-pin IOD wrappers, and replaces hand-wired single-pin delay control.

## Interface
- LANES, 8: number of command/address pins controlled (1..32)
- RATIO, 4: serialiser ratio, data bits per lane per FAB_CLK (2, 4 or 8)
- PIPE, 1: register stages on the data/OE path (1..4)
- MAX_TAP, 127: highest legal tap index; TAP_W = clog2(MAX_TAP+1)
- INIT_TAP, 1: tap value after reset or LOAD
- MOVE_GAP, 4: idle cycles after each MOVE pulse (1..15)
- IDLE_VAL, 1: data value driven during reset (command pins idle high)

- FAB_CLK  in  1  sole clock, rising edge
- ARST_N  in  1  reset; asynchronous, active-low
- CMD_DATA  in  LANES*RATIO  lane i at [i*RATIO +: RATIO], bit 0 transmitted first
- CMD_OE  in  LANES*RATIO  output enable per bit, same packing
- TX_DATA  out  LANES*RATIO  to IOD TX_DATA
- OE_DATA  out  LANES*RATIO  to IOD OE_DATA
- DLY_REQ_VALID  in  1  delay request valid
- DLY_REQ_READY  out  1  controller idle, request accepted when VALID&READY
- DLY_REQ_LANE  in  clog2(LANES)  target lane
- DLY_REQ_OP  in  2  00 increment, 01 decrement, 10 load, 11 reserved
- DLY_REQ_STEPS  in  8  number of tap moves for OP 00/01
- DLY_DONE  out  1  one-cycle completion pulse
- DLY_ERR  out  1  valid with DLY_DONE; 1 = aborted or illegal
- DLY_TAP  out  LANES*TAP_W  tracked tap per lane
- DELAY_LINE_MOVE / DELAY_LINE_DIRECTION / DELAY_LINE_LOAD  out  LANES  to IODs (DIRECTION 1 = increment)
- DELAY_LINE_OUT_OF_RANGE  in  LANES  from IODs

## Operation
- Data path: CMD_DATA/CMD_OE pass through PIPE register stages, no reordering. During reset TX_DATA = all IDLE_VAL and OE_DATA = 0.
- FSM states: IDLE, SETUP, MOVE, GAP, LOAD, DONE. DLY_REQ_READY = 1 only in IDLE.
- IDLE: on VALID&READY, latch lane, op and steps. OP 10 goes to LOAD; all other ops go to SETUP.
- SETUP: drives DIRECTION[lane]. Goes to DONE with ERR=1 if any of these hold:
  - OP = 11
  - lane ≥ LANES
  - increment with tap = MAX_TAP
  - decrement with tap = 0
- SETUP also goes to DONE with ERR=0 if steps = 0. Otherwise it goes to MOVE.
- MOVE: one-cycle MOVE[lane] pulse. Tap ±1, remaining steps −1. Goes to GAP.
- GAP: MOVE_GAP cycles, DIRECTION held. In the last GAP cycle:
  - OUT_OF_RANGE[lane] = 1 → DONE, ERR=1
  - remaining steps = 0 → DONE, ERR=0
  - next move would exceed 0..MAX_TAP → DONE, ERR=1
  - otherwise → MOVE
- LOAD: one-cycle LOAD[lane] pulse, tap := INIT_TAP, then DONE.
- DONE: DLY_DONE = 1 for one cycle, DLY_ERR valid, then IDLE.
- Only the addressed lane's MOVE/LOAD ever pulse. All other lanes' controls stay 0.
- VALID while busy is ignored; the requester holds it.
- Tap counters never wrap. An aborted sequence keeps the taps actually moved.
- Reset (any time, including mid-sequence):
  - MOVE/LOAD/DIRECTION = 0, DLY_DONE = 0, DLY_ERR = 0
  - READY = 0 while ARST_N low, 1 from the first edge after release
  - all DLY_TAP = INIT_TAP
  - no DONE is issued for the aborted request

## Timing
- Data latency: CMD_DATA at edge T appears on TX_DATA at edge T+PIPE.
- Request accepted at edge T:
  - DIRECTION valid from T+1.
  - First MOVE at T+2; move k at T+2+(k−1)(MOVE_GAP+1).
  - Clean N-step completion: DLY_DONE at T+2+N(MOVE_GAP+1).
  - LOAD, zero-step and SETUP errors: DLY_DONE at T+2 (LOAD pulse at T+1).
  - READY high at T+3+… (cycle after DONE).
- DIRECTION is stable one cycle before and throughout every MOVE pulse.
- DLY_TAP updates the edge after the MOVE/LOAD pulse.

## Test plan
- PIPE=2, CMD_DATA lane3 = 4'b1010 at T → TX_DATA[15:12] = 4'b1010 at T+2; during reset all TX_DATA = 1 and all OE = 0.
- Increment lane 5, STEPS=3, MOVE_GAP=4, accepted T → MOVE pulses at T+2/T+7/T+12, DONE at T+17 with ERR=0, DLY_TAP[5] 1→4.
- Decrement lane 0 from tap 1, STEPS=5 → one MOVE, tap 0, DONE ERR=1 at T+7; other lanes untouched.
- Increment lane 2 with OUT_OF_RANGE[2] raised after the 2nd MOVE → abort, DONE ERR=1 at T+12, tap = INIT_TAP+2.
- OP=10 on lane 7 after moves → LOAD pulse T+1, DONE T+2, tap = INIT_TAP; OP=11 → DONE ERR=1 at T+2, no pulses.
- ARST_N low between two MOVE pulses → all controls 0 immediately, no DONE, taps = INIT_TAP, READY at first edge after release.
